// File: rtl/fg_dac_spi_tx.sv
// Function-generator DAC output stage: signed sample -> offset-binary DAC code -> {CMD, code} SPI frame.
// Latency: busy_o the cycle after accept, (3+2*FRAME_BITS)*CLK_DIV cycles busy (+CLK_DIV with LDAC).
// Backpressure: strobes while busy are dropped with a one-cycle overrun_o pulse; FG_DAC_SPI_LDAC_EN adds an LDAC pulse.
module fg_dac_spi_tx #(
  parameter int                 BITWIDTH     = 16,
  parameter int                 DAC_BITWIDTH = 12,
  parameter int                 CMD_BITS     = 4,
  parameter logic [CMD_BITS-1:0] CMD         = 4'h3,
  parameter int                 CLK_DIV      = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                strobe_i,
  input  logic [BITWIDTH-1:0] sample_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o,
  output logic                cs_n_o,
  output logic                sclk_o,
  output logic                mosi_o,
  output logic                ldac_n_o
);

  localparam int FRAME_BITS = CMD_BITS + DAC_BITWIDTH;
  localparam int CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_LDAC
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  phase_q, phase_d;   // 0: sclk low half, 1: sclk high half
  logic [BW-1:0]         bit_q, bit_d;
  logic                  load, shift_en, frame_end, cnt_last, busy;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [BITWIDTH-1:0]   offs;
  logic [DAC_BITWIDTH-1:0] code;
  logic                  done_q, overrun_q;

  // Flipping the sign bit turns two's complement into offset binary; the
  // right shift drops the LSBs the DAC cannot resolve (no rounding needed,
  // the limiter upstream already bounds the value).
  assign offs     = sample_i ^ (BITWIDTH'(1) << (BITWIDTH - 1));
  assign code     = DAC_BITWIDTH'(offs >> (BITWIDTH - DAC_BITWIDTH));
  assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));
  assign busy     = (state_q != S_IDLE);

  // State and timing counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state: each phase lasts CLK_DIV cycles; SHIFT alternates low/high halves per bit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i && strobe_i) begin
          state_d = S_SETUP;
          load    = 1'b1;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_last) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BW'(FRAME_BITS - 1)) begin
              state_d = S_HOLD;
            end else begin
              // Next bit is presented at the start of the following low half
              bit_d    = bit_q + BW'(1);
              shift_en = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_last) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_last) begin
          cnt_d = '0;
`ifdef FG_DAC_SPI_LDAC_EN
          state_d = S_LDAC;
`else
          state_d   = S_IDLE;
          frame_end = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LDAC: begin
        if (cnt_last) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          frame_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame shift register: loaded only on accept so later sample changes are ignored
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= {CMD, code};
    end else if (shift_en) begin
      shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Status pulses: done after the last phase, overrun for a dropped strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= frame_end;
      overrun_q <= strobe_i && enable_i && busy;
    end
  end

  assign busy_o    = busy;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;
  assign cs_n_o    = (state_q == S_IDLE) || (state_q == S_GAP) || (state_q == S_LDAC);
  assign sclk_o    = (state_q == S_SHIFT) && phase_q;
  assign mosi_o    = ((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD))
                     ? shreg_q[FRAME_BITS-1] : 1'b0;
`ifdef FG_DAC_SPI_LDAC_EN
  assign ldac_n_o  = (state_q != S_LDAC);
`else
  assign ldac_n_o  = 1'b1;
`endif

endmodule

// File: tb/tb_fg_dac_spi_tx.sv
// Self-checking bench for fg_dac_spi_tx: reset, table vectors, random samples, overrun, back-to-back, reset abort.
// Latency: one frame per strobe, captured from sclk rising edges.
// Backpressure: strobes during busy must only raise overrun_o.
module tb_fg_dac_spi_tx;

`ifdef FG_DAC_SPI_LDAC_EN
  localparam int BUSY_EXP = 72;
  localparam int LDAC_EXP = 2;
`else
  localparam int BUSY_EXP = 70;
  localparam int LDAC_EXP = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        strobe_i;
  logic [15:0] sample_i;
  logic        busy_o, done_o, overrun_o, cs_n_o, sclk_o, mosi_o, ldac_n_o;

  int errors = 0;
  int checks = 0;

  // Monitor-owned counters; tests take snapshots instead of clearing
  int busy_cnt = 0, done_cnt = 0, ovr_cnt = 0, ldac_cnt = 0, nbits = 0;
  logic [15:0] cap = '0;
  int b_busy, b_done, b_ovr, b_ldac, b_bits;

  typedef struct {
    logic [15:0] sample;
    logic [15:0] frame;
  } vec_t;
  vec_t vecs [4];

  fg_dac_spi_tx dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .enable_i  (enable_i),
    .strobe_i  (strobe_i),
    .sample_i  (sample_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .overrun_o (overrun_o),
    .cs_n_o    (cs_n_o),
    .sclk_o    (sclk_o),
    .mosi_o    (mosi_o),
    .ldac_n_o  (ldac_n_o)
  );

  always #5 clk_i = ~clk_i;

  // Count status activity once per cycle, away from the active edge
  always @(negedge clk_i) begin
    if (busy_o) busy_cnt++;
    if (done_o) done_cnt++;
    if (overrun_o) ovr_cnt++;
    if (!ldac_n_o) ldac_cnt++;
  end

  // The DAC samples mosi on sclk rising edges
  always @(posedge sclk_o) begin
    cap = {cap[14:0], mosi_o};
    nbits++;
  end

  // Reference: offset-binary value of the sample scaled down to 12 bits, behind command 3
  function automatic logic [15:0] model_frame(input logic [15:0] s);
    int v;
    int c;
    v = int'($signed(s));
    c = (v + 32768) / 16;
    return 16'(3 * 4096 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_busy = busy_cnt; b_done = done_cnt; b_ovr = ovr_cnt; b_ldac = ldac_cnt; b_bits = nbits;
  endtask

  // Drive a strobe in the current cycle; returns just after the accepting edge
  task automatic launch_now(input logic [15:0] s);
    sample_i = s;
    enable_i = 1'b1;
    strobe_i = 1'b1;
    @(posedge clk_i);
    #1;
    strobe_i = 1'b0;
    sample_i = 16'($urandom);
    snap();
  endtask

  task automatic start(input logic [15:0] s);
    @(negedge clk_i);
    launch_now(s);
  endtask

  // Wait (bounded) for done_o, then verify the whole frame against the model
  task automatic finish(input logic [15:0] s, input string tag);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk_i);
      n++;
      if (done_o) seen = 1'b1;
    end
    #1;
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_frame"}, cap, model_frame(s));
    check({tag, "_nbits"}, nbits - b_bits, 16);
    check({tag, "_busy"}, busy_cnt - b_busy, BUSY_EXP);
    check({tag, "_done"}, done_cnt - b_done, 1);
    check({tag, "_ovr"}, ovr_cnt - b_ovr, 0);
    check({tag, "_ldac"}, ldac_cnt - b_ldac, LDAC_EXP);
  endtask

  initial begin
    vecs[0] = '{16'h7FFF, 16'h3FFF};
    vecs[1] = '{16'h8000, 16'h3000};
    vecs[2] = '{16'h0000, 16'h3800};
    vecs[3] = '{16'hFFFF, 16'h37FF};

    rst_i = 1'b1; enable_i = 1'b0; strobe_i = 1'b0; sample_i = '0;

    // Held in reset with strobes toggling: nothing may move
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      enable_i = 1'b1;
      strobe_i = ~strobe_i;
      sample_i = 16'($urandom);
    end
    @(negedge clk_i);
    check("rst_cs_n", cs_n_o, 1'b1);
    check("rst_sclk", sclk_o, 1'b0);
    check("rst_mosi", mosi_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_ovr", overrun_o, 1'b0);
    check("rst_ldac", ldac_n_o, 1'b1);
    check("rst_sclk_edges", nbits, 0);
    check("rst_busy_cycles", busy_cnt, 0);
    strobe_i = 1'b0;
    enable_i = 1'b0;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Table vectors: check the model itself, then the DUT
    for (int i = 0; i < 4; i++) begin
      check($sformatf("vec%0d_model", i), model_frame(vecs[i].sample), vecs[i].frame);
      start(vecs[i].sample);
      finish(vecs[i].sample, $sformatf("vec%0d", i));
    end

    // Random samples against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [15:0] s;
      s = 16'($urandom);
      start(s);
      finish(s, $sformatf("rnd%0d", i));
    end

    // Overrun: strobe mid-frame is dropped with a single pulse the next cycle
    begin
      logic [15:0] a;
      int b2;
      a = 16'h1234;
      start(a);
      repeat (19) @(negedge clk_i);
      sample_i = 16'h8000;
      strobe_i = 1'b1;
      @(posedge clk_i);
      #1;
      strobe_i = 1'b0;
      @(negedge clk_i);
      check("ovr_pulse", overrun_o, 1'b1);
      @(negedge clk_i);
      check("ovr_pulse_end", overrun_o, 1'b0);
      b_ovr = b_ovr + 1;
      finish(a, "ovr");
      b2 = busy_cnt;
      repeat (80) @(negedge clk_i);
      #1;
      check("ovr_no_second_frame", busy_cnt - b2, 0);
    end

    // Enable low: mid-frame strobe ignored without overrun; idle strobes ignored
    begin
      logic [15:0] a;
      a = 16'hC3A5;
      start(a);
      repeat (10) @(negedge clk_i);
      enable_i = 1'b0;
      strobe_i = 1'b1;
      @(negedge clk_i);
      strobe_i = 1'b0;
      finish(a, "en_low");
      snap();
      repeat (3) begin
        @(negedge clk_i);
        strobe_i = 1'b1;
        @(negedge clk_i);
        strobe_i = 1'b0;
      end
      repeat (20) @(negedge clk_i);
      #1;
      check("en_low_idle_busy", busy_cnt - b_busy, 0);
      check("en_low_idle_ovr", ovr_cnt - b_ovr, 0);
    end

    // Back-to-back: strobe in the done_o cycle starts the next frame at once
    begin
      logic [15:0] a, b;
      a = 16'h4000;
      b = 16'hBFFF;
      start(a);
      finish(a, "b2b_a");
      launch_now(b);
      check("b2b_busy_restart", busy_o, 1'b1);
      finish(b, "b2b_b");
    end

    // Reset mid-frame aborts at once, no done; next frame is clean
    begin
      logic [15:0] a;
      a = 16'h2AAA;
      start(a);
      repeat (29) @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      check("abort_cs_n", cs_n_o, 1'b1);
      check("abort_sclk", sclk_o, 1'b0);
      check("abort_busy", busy_o, 1'b0);
      check("abort_mosi", mosi_o, 1'b0);
      snap();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (20) @(negedge clk_i);
      #1;
      check("abort_no_done", done_cnt - b_done, 0);
      start(16'h5555);
      finish(16'h5555, "after_abort");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
